tempo_divider: RTL and testbench
================================

TEMPO_DIVIDER -- requirements
Module: tempo_divider

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16: width of each channel's period and tick counter.
REQ-002 The block SHALL have parameter NUM_CH, default 4: number of independent beat channels.
REQ-003 The block SHALL have parameter BEAT_BITS, default 4: width of the beat-in-bar index.
REQ-004 The block SHALL have parameter DEFAULT_PERIOD, default 4800: per-channel period loaded at reset.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have port count_en, input, 1 bit: the sample tick; one count per high cycle.
REQ-008 The block SHALL have port ch_en, input, NUM_CH bits: per-channel count enable.
REQ-009 The block SHALL have port sync, input, 1 bit: restarts all channels in phase.
REQ-010 The block SHALL have port period_wr, input, 1 bit: period write strobe.
REQ-011 The block SHALL have port period_ch, input, clog2(NUM_CH) bits: the channel that period_wr targets.
REQ-012 The block SHALL have port period_data, input, WIDTH bits: the new period.
REQ-013 The block SHALL have port bar_len, input, BEAT_BITS bits: beats per bar, shared by all channels.
REQ-014 The block SHALL have port beat, output, NUM_CH bits: one-cycle beat pulse per channel.
REQ-015 The block SHALL have port downbeat, output, NUM_CH bits: one-cycle pulse on the first beat of a bar.
REQ-016 The block SHALL have port beat_idx, output, NUM_CH*BEAT_BITS bits: packed current beat index, with channel i at bits [i*BEAT_BITS +: BEAT_BITS].

Function
REQ-017 A channel i SHALL count in a cycle only when the cycle is active: count_en=1, ch_en[i]=1, sync=0, reset=0 and period P[i]!=0.
REQ-018 In an active cycle with cnt[i]==0, the block SHALL assert beat[i] for exactly one cycle on the following cycle (1-cycle registered latency).
REQ-019 In an active cycle, cnt[i] SHALL become 0 if cnt[i] >= P[i]-1, else cnt[i]+1; the compare SHALL be unsigned, with no WIDTH overflow.
REQ-020 With P[i]=1, beat[i] SHALL follow every active count_en one cycle later; with P[i]=0, the channel SHALL be disabled, with cnt and beat_idx held and no beats.
REQ-021 With count_en or ch_en[i] low, cnt[i] and beat_idx[i] SHALL hold, and beat[i] and downbeat[i] SHALL be 0 the next cycle.
REQ-022 period_wr=1 SHALL load period_data into P[period_ch] at the clock edge; the tick counted in that same cycle SHALL use the old P.
REQ-023 After a period write that makes cnt[i] >= new P-1, the next active cycle SHALL wrap cnt[i] to 0; no mid-period beat SHALL be inserted.
REQ-024 beat_idx[i] SHALL update in the same cycle that beat[i] asserts: beat_idx = 0 if beat_idx >= bar_len-1, else beat_idx+1.
REQ-025 downbeat[i] SHALL assert together with beat[i] when the beat_idx value before that update is 0.
REQ-026 With bar_len 0 or 1, every beat SHALL be a downbeat and beat_idx SHALL stay 0.
REQ-027 sync=1 SHALL clear all cnt and beat_idx to 0 and SHALL give beat=downbeat=0 the next cycle; sync SHALL override a simultaneous count_en, while a simultaneous period_wr SHALL still take effect.
REQ-028 Channels SHALL be fully independent, apart from the shared count_en, sync and bar_len.

Reset
REQ-029 In a reset cycle, the next edge SHALL set all P to DEFAULT_PERIOD and clear all cnt and beat_idx to 0.
REQ-030 In a reset cycle, the next edge SHALL set beat and downbeat to 0, and they SHALL also be combinationally forced to 0 while reset=1.
REQ-031 reset SHALL override sync, period_wr and count_en; reset mid-period SHALL discard the phase, and the first active tick after release SHALL produce a beat, which SHALL be a downbeat.

Structure
REQ-032 A shared package beat_pkg SHALL hold the constants WIDTH, BEAT_BITS, DEFAULT_PERIOD and the sample-rate constant (48000).
REQ-033 The block SHALL contain one sub-module, beat_ch (a single channel: period register, counter, beat_idx, registered pulses), instantiated NUM_CH times with a generate loop.
REQ-034 All flops SHALL use the team's dffr/dffre primitives, with no latches and no combinational path from inputs to beat except the reset mask.

Verification
REQ-035 Scenario 1: reset, P=4, count_en=1 every cycle, bar_len=4, ch_en=1. Required response: beat at cycles 1,5,9,13,…; downbeat at cycles 1,17,…; beat_idx sequence 1,2,3,0.
REQ-036 Scenario 2: count_en high 1 cycle in 3, P=DEFAULT_PERIOD. Required response: beats exactly 14400 cycles apart, each 1 cycle wide.
REQ-037 Scenario 3: P=10, write period_data=3 when cnt=7. Required response: the next active tick wraps to 0 (beat one cycle later), then a period of 3.
REQ-038 Scenario 4: sync asserted with count_en on cnt=0 on ch0/ch1 with different P. Required response: no beat that cycle; both channels then beat on the same cycle on the next tick.
REQ-039 Scenario 5: P=0 on ch2 and ch_en[3]=0 while ch0 runs. Required response: ch2/ch3 produce no pulses and hold state; ch0 is unaffected.
REQ-040 Scenario 6: reset asserted mid-bar (beat_idx=2, cnt=5). Required response: all outputs are 0 during reset; after release, the first tick gives beat=downbeat=1 and P returns to 4800.

Source files
------------

// File: rtl/beat_pkg.sv
`default_nettype none
// ============================================================================
// Module      : beat_pkg
// Description : Shared constants for the tempo divider channels.
// Revision    : 1.0 - initial release
// ============================================================================
package beat_pkg;

    localparam int c_sample_rate    = 48000;
    localparam int c_width          = 16;
    localparam int c_beat_bits      = 4;
    // Ten beats per second at the nominal sample rate.
    localparam int c_default_period = c_sample_rate / 10;

    // Samples per beat for a tempo in beats per minute; 0 disables a channel.
    function automatic int bpm_to_period(input int bpm);
        if (bpm <= 0) begin
            return 0;
        end
        return (c_sample_rate * 60) / bpm;
    endfunction

endpackage : beat_pkg
`default_nettype wire

// File: rtl/beat_ch.sv
`default_nettype none
// ============================================================================
// Module      : beat_ch
// Description : One beat channel: period register, tick counter, bar position
//               and registered beat/downbeat pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module beat_ch
    import beat_pkg::*;
#(
    parameter int WIDTH          = c_width,
    parameter int BEAT_BITS      = c_beat_bits,
    parameter int DEFAULT_PERIOD = c_default_period
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_count_en,
    input  logic                 i_ch_en,
    input  logic                 i_sync,
    input  logic                 i_period_wr,
    input  logic [WIDTH-1:0]     i_period_data,
    input  logic [BEAT_BITS-1:0] i_bar_len,
    output logic                 o_beat,
    output logic                 o_downbeat,
    output logic [BEAT_BITS-1:0] o_beat_idx
);

    localparam logic [WIDTH-1:0]     c_cnt_one    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [BEAT_BITS-1:0] c_idx_one    = {{(BEAT_BITS-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]     c_period_rst = WIDTH'(DEFAULT_PERIOD);

    logic [WIDTH-1:0]     r_period;
    logic [WIDTH-1:0]     r_cnt;
    logic [BEAT_BITS-1:0] r_idx;
    logic [1:0]           r_pulse;

    logic                 w_active;
    logic                 w_tick;
    logic                 w_cnt_last;
    logic                 w_bar_last;
    logic                 w_cnt_en;
    logic [WIDTH-1:0]     w_cnt_d;
    logic                 w_idx_en;
    logic [BEAT_BITS-1:0] w_idx_d;
    logic [1:0]           w_pulse_d;

    always_comb begin
        // A zero period parks the channel; reset is handled by the flops.
        w_active   = i_count_en & i_ch_en & ~i_sync & (r_period != '0);
        w_tick     = w_active & (r_cnt == '0);
        // Greater-or-equal also recovers a counter left beyond a shrunk period.
        w_cnt_last = (r_cnt >= (r_period - c_cnt_one));
        w_bar_last = (i_bar_len <= c_idx_one) | (r_idx >= (i_bar_len - c_idx_one));

        w_cnt_en   = i_sync | w_active;
        w_cnt_d    = (i_sync | w_cnt_last) ? '0 : (r_cnt + c_cnt_one);

        w_idx_en   = i_sync | w_tick;
        w_idx_d    = (i_sync | w_bar_last) ? '0 : (r_idx + c_idx_one);

        w_pulse_d  = {w_tick, w_tick & (r_idx == '0)};
    end

    dffre #(
        .WIDTH     (WIDTH),
        .RESET_VAL (c_period_rst)
    ) u_period (
        .clk  (clk),
        .rst  (rst),
        .i_en (i_period_wr),
        .i_d  (i_period_data),
        .o_q  (r_period)
    );

    dffre #(
        .WIDTH     (WIDTH),
        .RESET_VAL ('0)
    ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .i_en (w_cnt_en),
        .i_d  (w_cnt_d),
        .o_q  (r_cnt)
    );

    dffre #(
        .WIDTH     (BEAT_BITS),
        .RESET_VAL ('0)
    ) u_idx (
        .clk  (clk),
        .rst  (rst),
        .i_en (w_idx_en),
        .i_d  (w_idx_d),
        .o_q  (r_idx)
    );

    dffr #(
        .WIDTH     (2),
        .RESET_VAL (2'b00)
    ) u_pulse (
        .clk (clk),
        .rst (rst),
        .i_d (w_pulse_d),
        .o_q (r_pulse)
    );

    // Pulses are masked while reset is held so nothing leaks during reset.
    assign o_beat     = r_pulse[1] & ~rst;
    assign o_downbeat = r_pulse[0] & ~rst;
    assign o_beat_idx = r_idx;

endmodule : beat_ch
`default_nettype wire

// File: rtl/dffr.sv
`default_nettype none
// ============================================================================
// Module      : dffr
// Description : Free-running register with synchronous active-high reset.
// Revision    : 1.0 - initial release
// ============================================================================
module dffr #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            o_q <= RESET_VAL;
        end else begin
            o_q <= i_d;
        end
    end

endmodule : dffr
`default_nettype wire

// File: rtl/dffre.sv
`default_nettype none
// ============================================================================
// Module      : dffre
// Description : Register with load enable; synchronous reset wins over enable.
// Revision    : 1.0 - initial release
// ============================================================================
module dffre #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            o_q <= RESET_VAL;
        end else if (i_en) begin
            o_q <= i_d;
        end
    end

endmodule : dffre
`default_nettype wire

// File: rtl/tempo_divider.sv
`default_nettype none
// ============================================================================
// Module      : tempo_divider
// Description : Multi-channel tempo divider producing beat and downbeat pulses
//               from a shared sample tick.
// Revision    : 1.0 - initial release
// ============================================================================
module tempo_divider
    import beat_pkg::*;
#(
    parameter int WIDTH          = c_width,
    parameter int NUM_CH         = 4,
    parameter int BEAT_BITS      = c_beat_bits,
    parameter int DEFAULT_PERIOD = c_default_period
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        count_en,
    input  logic [NUM_CH-1:0]           ch_en,
    input  logic                        sync,
    input  logic                        period_wr,
    input  logic [$clog2(NUM_CH)-1:0]   period_ch,
    input  logic [WIDTH-1:0]            period_data,
    input  logic [BEAT_BITS-1:0]        bar_len,
    output logic [NUM_CH-1:0]           beat,
    output logic [NUM_CH-1:0]           downbeat,
    output logic [NUM_CH*BEAT_BITS-1:0] beat_idx
);

    localparam int CH_BITS = $clog2(NUM_CH);

    logic [NUM_CH-1:0] w_period_wr;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign w_period_wr[i] = period_wr & (period_ch == CH_BITS'(i));

        beat_ch #(
            .WIDTH          (WIDTH),
            .BEAT_BITS      (BEAT_BITS),
            .DEFAULT_PERIOD (DEFAULT_PERIOD)
        ) u_beat_ch (
            .clk           (clk),
            .rst           (reset),
            .i_count_en    (count_en),
            .i_ch_en       (ch_en[i]),
            .i_sync        (sync),
            .i_period_wr   (w_period_wr[i]),
            .i_period_data (period_data),
            .i_bar_len     (bar_len),
            .o_beat        (beat[i]),
            .o_downbeat    (downbeat[i]),
            .o_beat_idx    (beat_idx[i*BEAT_BITS +: BEAT_BITS])
        );
    end

endmodule : tempo_divider
`default_nettype wire

// File: tb/tb_tempo_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_tempo_divider
// Description : Directed and randomized self-checking bench for tempo_divider.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tempo_divider;

    localparam int WIDTH          = 16;
    localparam int NUM_CH         = 4;
    localparam int BEAT_BITS      = 4;
    localparam int DEFAULT_PERIOD = 4800;

    logic                        clk = 1'b0;
    logic                        reset;
    logic                        count_en;
    logic [NUM_CH-1:0]           ch_en;
    logic                        sync;
    logic                        period_wr;
    logic [1:0]                  period_ch;
    logic [WIDTH-1:0]            period_data;
    logic [BEAT_BITS-1:0]        bar_len;
    logic [NUM_CH-1:0]           beat;
    logic [NUM_CH-1:0]           downbeat;
    logic [NUM_CH*BEAT_BITS-1:0] beat_idx;

    always #5 clk = ~clk;

    tempo_divider #(
        .WIDTH          (WIDTH),
        .NUM_CH         (NUM_CH),
        .BEAT_BITS      (BEAT_BITS),
        .DEFAULT_PERIOD (DEFAULT_PERIOD)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .count_en    (count_en),
        .ch_en       (ch_en),
        .sync        (sync),
        .period_wr   (period_wr),
        .period_ch   (period_ch),
        .period_data (period_data),
        .bar_len     (bar_len),
        .beat        (beat),
        .downbeat    (downbeat),
        .beat_idx    (beat_idx)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cycle       = 0;

    // Reference state: samples into the current beat, beat position in bar.
    int m_p   [NUM_CH];
    int m_cnt [NUM_CH];
    int m_idx [NUM_CH];
    logic [NUM_CH-1:0]           exp_beat;
    logic [NUM_CH-1:0]           exp_db;
    logic [NUM_CH*BEAT_BITS-1:0] exp_idx;

    function automatic void model_step();
        for (int i = 0; i < NUM_CH; i++) begin
            int new_p;
            new_p = (period_wr && (int'(period_ch) == i)) ? int'(period_data) : m_p[i];
            exp_beat[i] = 1'b0;
            exp_db[i]   = 1'b0;
            if (reset) begin
                m_p[i]   = DEFAULT_PERIOD;
                m_cnt[i] = 0;
                m_idx[i] = 0;
            end else begin
                if (sync) begin
                    m_cnt[i] = 0;
                    m_idx[i] = 0;
                end else if (count_en && ch_en[i] && (m_p[i] != 0)) begin
                    if (m_cnt[i] == 0) begin
                        exp_beat[i] = 1'b1;
                        exp_db[i]   = (m_idx[i] == 0);
                        m_idx[i]    = (m_idx[i] + 1 >= int'(bar_len)) ? 0 : m_idx[i] + 1;
                    end
                    m_cnt[i] = (m_cnt[i] + 1 >= m_p[i]) ? 0 : m_cnt[i] + 1;
                end
                m_p[i] = new_p;
            end
            exp_idx[i*BEAT_BITS +: BEAT_BITS] = BEAT_BITS'(m_idx[i]);
        end
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, expv, cycle);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        cycle++;
        check("beat", 64'(beat), 64'(exp_beat));
        check("downbeat", 64'(downbeat), 64'(exp_db));
        check("beat_idx", 64'(beat_idx), 64'(exp_idx));
    endtask

    task automatic write_period(input int ch, input int value);
        period_wr   = 1'b1;
        period_ch   = 2'(ch);
        period_data = WIDTH'(value);
        tick();
        period_wr   = 1'b0;
    endtask

    initial begin
        int last;
        int nb;
        int n0;
        int gap;
        logic [4:0] s3_pat;

        reset = 1'b1; sync = 1'b0; count_en = 1'b0; ch_en = '1;
        period_wr = 1'b0; period_ch = '0; period_data = '0; bar_len = 4'd4;
        tick();
        tick();
        check("reset_beat", 64'(beat), 64'd0);
        check("reset_idx", 64'(beat_idx), 64'd0);
        reset = 1'b0;

        // Scenario 1: P=4, bar of 4, continuous ticks
        for (int ch = 0; ch < NUM_CH; ch++) write_period(ch, 4);
        count_en = 1'b1;
        for (int k = 1; k <= 21; k++) begin
            tick();
            check("s1_beat", 64'(beat[0]), 64'(k % 4 == 1));
            check("s1_down", 64'(downbeat[0]), 64'(k % 16 == 1));
            if (k % 4 == 1) check("s1_idx", 64'(beat_idx[3:0]), 64'(((k - 1) / 4 + 1) % 4));
        end
        // Reset mask: beat is high now and must drop as soon as reset rises
        reset = 1'b1;
        #1;
        check("mask_beat", 64'(beat), 64'd0);
        check("mask_down", 64'(downbeat), 64'd0);
        tick();
        reset = 1'b0;

        // Scenario 2: default period, one tick in three
        last = -1;
        nb   = 0;
        for (int j = 0; j < 45000 && nb < 3; j++) begin
            count_en = (j % 3 == 0);
            tick();
            if (beat[0] === 1'b1) begin
                if (last >= 0) check("s2_gap", 64'(cycle - last), 64'd14400);
                last = cycle;
                nb++;
            end
        end
        check("s2_beats", 64'(nb), 64'd3);

        // Scenario 3: shrink period from 10 to 3 while cnt=7
        count_en = 1'b0;
        reset = 1'b1; tick(); reset = 1'b0;
        write_period(0, 10);
        count_en = 1'b1;
        repeat (7) tick();
        count_en = 1'b0;
        write_period(0, 3);
        count_en = 1'b1;
        s3_pat = 5'b10010;
        for (int t = 0; t < 5; t++) begin
            tick();
            check("s3_beat", 64'(beat[0]), 64'(s3_pat[t]));
        end

        // Scenario 4: sync with count_en, different periods on ch0/ch1
        count_en = 1'b0;
        write_period(0, 3);
        write_period(1, 5);
        count_en = 1'b1;
        repeat (6) tick();
        sync = 1'b1;
        tick();
        check("s4_sync", 64'(beat[1:0]), 64'd0);
        sync = 1'b0;
        tick();
        check("s4_inphase", 64'(beat[1:0]), 64'd3);

        // Scenario 5: ch2 disabled by P=0, ch3 by ch_en
        count_en = 1'b0;
        ch_en = 4'b0111;
        write_period(2, 0);
        count_en = 1'b1;
        n0 = 0;
        for (int t = 0; t < 24; t++) begin
            tick();
            check("s5_quiet", 64'({beat[3:2], downbeat[3:2]}), 64'd0);
            if (beat[0] === 1'b1) n0++;
        end
        check("s5_ch0", 64'(n0), 64'd8);

        // Scenario 6: reset mid-bar at beat_idx=2, cnt=5
        ch_en = '1;
        count_en = 1'b0;
        reset = 1'b1; tick(); reset = 1'b0;
        write_period(0, 8);
        count_en = 1'b1;
        repeat (13) tick();
        check("s6_pre_idx", 64'(beat_idx[3:0]), 64'd2);
        reset = 1'b1;
        tick();
        check("s6_rst", 64'({beat, downbeat}), 64'd0);
        tick();
        reset = 1'b0;
        tick();
        check("s6_first", 64'({beat[0], downbeat[0]}), 64'd3);
        gap = -1;
        for (int j = 0; j < 6000; j++) begin
            tick();
            if (beat[0] === 1'b1) begin
                gap = j + 1;
                break;
            end
        end
        check("s6_period", 64'(gap), 64'd4800);

        // Randomized traffic against the reference model
        for (int j = 0; j < 1500; j++) begin
            count_en    = 1'($urandom);
            ch_en       = NUM_CH'($urandom);
            sync        = ($urandom_range(0, 39) == 0);
            reset       = ($urandom_range(0, 199) == 0);
            period_wr   = ($urandom_range(0, 7) == 0);
            period_ch   = 2'($urandom);
            period_data = WIDTH'($urandom_range(0, 6));
            bar_len     = BEAT_BITS'($urandom_range(0, 5));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_tempo_divider
`default_nettype wire
